// File: rtl/data_mem_responder_if.sv
// Request/response bus between a memory client (master) and data_mem_responder (slave).
// Handshake: a beat transfers on a rising clk edge where valid & ready are both 1; the sender holds its payload stable while valid is 1 and ready is 0.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        memRead;
    logic        memWrite;
    logic [3:0]  xferSize;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rdata;
    logic        rsp_err;

    modport master (
        output req_valid, memRead, memWrite, xferSize, addr, wdata, rsp_ready,
        input  req_ready, rsp_valid, rdata, rsp_err
    );

    modport slave (
        input  req_valid, memRead, memWrite, xferSize, addr, wdata, rsp_ready,
        output req_ready, rsp_valid, rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Byte-addressed little-endian scratch memory that serves one load/store at a time
// with a fixed wait latency, registered response and range/alignment checking.
module data_mem_responder #(
    parameter int DEPTH_BYTES = 128,
    parameter int LATENCY     = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    data_mem_responder_if.slave   bus,
    // FSM state: 0 = IDLE, 1 = ACCESS, 2 = RESP
    output logic [1:0]            dbg_state
);

    localparam int          AW        = $clog2(DEPTH_BYTES);
    localparam logic [3:0]  CNT_LAST  = 4'(LATENCY - 1);
    localparam logic [64:0] DEPTH_END = 65'(DEPTH_BYTES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [3:0]  cnt;
    logic        q_read;
    logic        q_write;
    logic [3:0]  q_xfer;
    logic [63:0] q_addr;
    logic [63:0] q_wdata;

    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [63:0] rdata_q;

    logic        req_ready;
    logic        accept;
    logic        do_access;
    logic        rsp_done;

    logic [64:0] end_addr;
    logic        size_bad;
    logic        acc_err;
    logic [AW-1:0] base;
    logic [63:0] load_data;

    logic [7:0]  mem [DEPTH_BYTES];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (bus.req_valid)        state_nxt = S_ACCESS;
            S_ACCESS: if (cnt == CNT_LAST)      state_nxt = S_RESP;
            S_RESP:   if (bus.rsp_ready)        state_nxt = S_IDLE;
            default:                            state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: output decode ----------------
    always_comb begin
        req_ready = 1'b0;
        accept    = 1'b0;
        do_access = 1'b0;
        rsp_done  = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                accept    = bus.req_valid;
            end
            S_ACCESS: do_access = (cnt == CNT_LAST);
            S_RESP:   rsp_done  = bus.rsp_ready;
            default: ;
        endcase
    end

    assign dbg_state     = state;
    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rdata     = rdata_q;

    // ---------------- Request checking ----------------
    // The end address is formed in 65 bits so a request near 2^64 cannot wrap back into range.
    always_comb begin
        end_addr = {1'b0, q_addr} + {61'b0, q_xfer};
        size_bad = (q_xfer != 4'd1) && (q_xfer != 4'd8);
        acc_err  = (q_read == q_write)
                || size_bad
                || ((q_xfer == 4'd8) && (q_addr[2:0] != 3'd0))
                || (end_addr > DEPTH_END);
    end

    assign base = q_addr[AW-1:0];

    // ---------------- Storage read path ----------------
    always_comb begin
        load_data = '0;
        if (q_xfer == 4'd8) begin
            for (int i = 0; i < 8; i++) begin
                load_data[8*i +: 8] = mem[base + AW'(i)];
            end
        end else begin
            load_data[7:0] = mem[base];
        end
    end

    // ---------------- Storage write path ----------------
    // No reset here: contents survive reset. An access aborted by reset never
    // reaches this edge because reset forces the FSM out of ACCESS.
    always_ff @(posedge clk) begin
        if (do_access && !acc_err && q_write) begin
            if (q_xfer == 4'd8) begin
                for (int i = 0; i < 8; i++) begin
                    mem[base + AW'(i)] <= q_wdata[8*i +: 8];
                end
            end else begin
                mem[base] <= q_wdata[7:0];
            end
        end
    end

    // ---------------- Request capture and wait counter ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            q_read  <= 1'b0;
            q_write <= 1'b0;
            q_xfer  <= '0;
            q_addr  <= '0;
            q_wdata <= '0;
        end else if (accept) begin
            cnt     <= '0;
            q_read  <= bus.memRead;
            q_write <= bus.memWrite;
            q_xfer  <= bus.xferSize;
            q_addr  <= bus.addr;
            q_wdata <= bus.wdata;
        end else if (state == S_ACCESS) begin
            cnt <= cnt + 4'd1;
        end
    end

    // ---------------- Registered response ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rdata_q     <= '0;
        end else if (do_access) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= acc_err;
            rdata_q     <= (acc_err || !q_read) ? 64'd0 : load_data;
        end else if (rsp_done) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rdata_q     <= '0;
        end
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_BYTES, default 128, meaning byte capacity of internal storage; a power of 2, minimum 16.
REQ-002 Parameter LATENCY, default 2, meaning the number of wait cycles in ACCESS; range 1-15.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 Port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port req_valid, input, 1 bit: a request is present.
REQ-006 Port req_ready, output, 1 bit: the block accepts a request this cycle.
REQ-007 Port memRead, input, 1 bit: the request is a load.
REQ-008 Port memWrite, input, 1 bit: the request is a store.
REQ-009 Port xferSize, input, 4 bits: transfer size in bytes; legal values are 4'b0001 and 4'b1000.
REQ-010 Port addr, input, 64 bits: byte address.
REQ-011 Port wdata, input, 64 bits: store data; a byte store uses wdata[7:0].
REQ-012 Port rsp_valid, output, 1 bit: a response is present.
REQ-013 Port rsp_ready, input, 1 bit: the consumer accepts the response.
REQ-014 Port rdata, output, 64 bits: load data; zero-extended for byte loads; 0 for stores and errors.
REQ-015 Port rsp_err, output, 1 bit: the request was rejected; storage is not modified.

Function
REQ-016 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-017 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid & req_ready.
REQ-018 On accept, the block SHALL capture memRead, memWrite, xferSize, addr and wdata, clear the wait counter, and go to ACCESS.
REQ-019 In ACCESS, the counter SHALL increment each cycle; when it equals LATENCY-1, the block SHALL perform the access and go to RESP.
REQ-020 Accept-to-rsp_valid latency SHALL be exactly LATENCY+1 cycles.
REQ-021 Error conditions SHALL be any of:
- memRead == memWrite
- xferSize not legal
- xferSize 8 with addr[2:0] != 0
- addr + size > DEPTH_BYTES (computed without 64-bit wrap)
REQ-022 On error, the block SHALL set rsp_err=1, set rdata=0, and leave storage unchanged.
REQ-023 Storage SHALL be little-endian: byte addr+i holds data bits [8i+7:8i].
REQ-024 An 8-byte store SHALL write bytes addr..addr+7; a byte store SHALL write byte addr only.
REQ-025 An 8-byte load SHALL return bytes addr..addr+7; a byte load SHALL return {56'b0, byte[addr]}.
REQ-026 rsp_valid, rdata and rsp_err SHALL be registered and held stable in RESP until rsp_ready=1.
REQ-027 When rsp_valid & rsp_ready, the block SHALL return to IDLE.
- A new request is accepted no earlier than the next cycle; there is no back-to-back bypass.
REQ-028 req_valid asserted outside IDLE SHALL be ignored, with no capture or queuing.
REQ-029 A load following a store to the same address SHALL return the stored data, because accesses are fully serialized.

Reset
REQ-030 Asserting reset_n=0 SHALL immediately, without waiting for clk, force:
- state to IDLE
- counter to 0
- rsp_valid, rsp_err and rdata to 0
- req_ready to 1 after release
REQ-031 Reset SHALL NOT clear storage contents.
REQ-032 Reset asserted during ACCESS SHALL abort the request, and no storage write SHALL occur if reset is asserted before the access edge.
REQ-033 Reset asserted during RESP SHALL drop the pending response.

Verification
REQ-034 8-byte store with addr=0x10, wdata=0x1122334455667788, followed by an 8-byte load with addr=0x10 -> rdata=0x1122334455667788, rsp_err=0; with LATENCY=2, rsp_valid rises 3 cycles after accept.
REQ-035 Byte load with addr=0x13 after REQ-034 -> rdata=0x0000000000000055; byte store of 0xAB to 0x13, then 8-byte load of 0x10 -> 0x11223344AB667788.
REQ-036 Each of these requests -> rsp_err=1, rdata=0, and a subsequent load shows storage unchanged:
- 8-byte load at 0x0C
- xferSize=4'b0100
- memRead=memWrite=1
- 8-byte access at DEPTH_BYTES-4
REQ-037 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rdata and rsp_err are stable and req_ready=0; raise rsp_ready -> IDLE the next cycle; req_valid pulses during the stall are not accepted.
REQ-038 Assert reset_n=0 mid-ACCESS of a store -> outputs are 0 asynchronously, the store is not performed, and after release req_ready=1.
REQ-039 Byte accesses at addr 0 and at DEPTH_BYTES-1 succeed; a byte access at DEPTH_BYTES errors.
